// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory via req/ack, holds the
// fetched word until the core retires it, and latches a sticky timeout error.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [15:0] immediate,
    input  logic [31:0] sign_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      PC_RST    = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      pc_d;
    logic [31:0]      instr_d;
    logic [31:0]      next_pc;
    logic             valid_d;
    logic             req_d;
    logic             err_d;

    // Address and immediate are direct views of registered state.
    assign imem_addr = pc;
    assign immediate = instr[15:0];

    // Redirect target: jump has priority over a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + (sign_imm << 2);
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            pc          <= PC_RST;
            pc_plus4    <= PC_RST + 32'd4;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc          <= pc_d;
            pc_plus4    <= pc_d + 32'd4;
            instr       <= instr_d;
            instr_valid <= valid_d;
            imem_req    <= req_d;
            fetch_err   <= err_d;
        end
    end

    // Next-state and next-output logic; ack on the limit cycle wins over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc;
        instr_d = instr;
        valid_d = instr_valid;
        req_d   = 1'b0;
        err_d   = fetch_err;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    req_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ERROR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                cnt_d   = '0;
                valid_d = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
